// File: rtl/au_packetizer_if.sv
// -----------------------------------------------------------------------------
// au_packetizer_if
// Groups the signals exchanged between the audio packetizer and its neighbours:
// the PCM sample strobe from the decimation filters, the Ethernet transmitter
// handshake, the BRAM write port and the drop counter.
//   slave  : the packetizer side (consumes samples, drives BRAM and eth_start)
//   master : the environment side (filters, transmitter, BRAM)
// Signals:
//   stb_pcm        one-cycle strobe, pcm_l/pcm_r valid
//   pcm_l, pcm_r   signed 16-bit left/right samples
//   eth_busy       transmitter busy
//   eth_start      one-cycle frame start strobe
//   eth_bank       half-buffer the transmitter must read
//   bram_wr_en     BRAM write enable
//   bram_wr_addr   {bank, 7-bit offset}
//   bram_wr_data   write byte
//   drop_cnt       dropped samples plus dropped frames, saturating
// -----------------------------------------------------------------------------
interface au_packetizer_if;
   logic        stb_pcm;
   logic [15:0] pcm_l;
   logic [15:0] pcm_r;
   logic        eth_busy;
   logic        eth_start;
   logic        eth_bank;
   logic        bram_wr_en;
   logic [7:0]  bram_wr_addr;
   logic [7:0]  bram_wr_data;
   logic [7:0]  drop_cnt;

   modport slave (
      input  stb_pcm, pcm_l, pcm_r, eth_busy,
      output eth_start, eth_bank, bram_wr_en, bram_wr_addr, bram_wr_data, drop_cnt
   );

   modport master (
      output stb_pcm, pcm_l, pcm_r, eth_busy,
      input  eth_start, eth_bank, bram_wr_en, bram_wr_addr, bram_wr_data, drop_cnt
   );
endinterface

// File: rtl/au_packetizer.sv
// -----------------------------------------------------------------------------
// au_packetizer
// Double-buffered audio packetizer. Stereo PCM samples are written into one
// 128-byte half of a 256-byte BRAM while the Ethernet transmitter reads the
// other half. Each half starts with a 14-byte Ethernet header (written once
// after reset), a 2-byte big-endian sequence number, then 4 bytes per sample
// (L lo, L hi, R lo, R hi). A completed half is handed over with a one-cycle
// eth_start and eth_bank naming the half to read.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset
//   bus    au_packetizer_if.slave (samples, transmitter handshake, BRAM port,
//          drop counter)
// Build option:
//   AU_PACKETIZER_SEQ_EN  when defined, bytes 14-15 carry a frame sequence
//                         counter; otherwise they are written as 8'h00.
// -----------------------------------------------------------------------------
module au_packetizer #(
   parameter int unsigned SAMPLES_PER_FRAME = 28,
   parameter logic [47:0] DST_MAC           = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC           = 48'h0200_0000_0001,
   parameter logic [15:0] ETHERTYPE         = 16'h88B5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   au_packetizer_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_SAMP   = 3'd2,
      ST_SEQ    = 3'd3,
      ST_COMMIT = 3'd4
   } state_t;

   localparam logic [111:0] HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};
   localparam logic [4:0]   LAST_IDX = 5'(SAMPLES_PER_FRAME - 1);

   // Header byte idx (0..13), MSB-first through the header constant.
   function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
      logic [111:0] s;
      s = HDR >> {4'd13 - idx, 3'b000};
      return s[7:0];
   endfunction

   // Byte k of a {R,L} sample word, giving L lo, L hi, R lo, R hi order.
   function automatic logic [7:0] samp_byte(input logic [31:0] w, input logic [1:0] k);
      logic [31:0] s;
      s = w >> {k, 3'b000};
      return s[7:0];
   endfunction

   // Saturating add of up to two single-event increments.
   function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic a, input logic b);
      logic [8:0] s;
      s = {1'b0, cnt} + {8'h00, a} + {8'h00, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   state_t      state_q;
   logic [3:0]  init_off_q;
   logic        init_bank_q;
   logic [1:0]  byte_q;        // next byte to emit in SAMP/SEQ; 0 in SAMP = done
   logic [4:0]  sample_cnt_q;
   logic        fill_bank_q;
   logic        pending_q;
   logic [31:0] cap_q;         // capture register, {R, L}
   logic [31:0] work_q;        // sample being written; frees cap_q for the next strobe
   logic        eth_start_q;
   logic        eth_bank_q;
   logic        wr_en_q;
   logic [7:0]  wr_addr_q;
   logic [7:0]  wr_data_q;
   logic [7:0]  drop_q;

   logic [15:0] seq_s;
   logic [6:0]  samp_base_s;
   logic        stb_take_s;
   logic        stb_drop_s;
   logic        seq_last_s;
   logic        commit_ok_s;
   logic        frame_drop_s;

   assign samp_base_s = 7'd16 + {sample_cnt_q, 2'b00};

   // Strobe acceptance and commit decision.
   always_comb begin
      stb_take_s   = 1'b0;
      stb_drop_s   = 1'b0;
      if (bus.stb_pcm) begin
         if ((state_q == ST_INIT) || pending_q) begin
            stb_drop_s = 1'b1;
         end else begin
            stb_take_s = 1'b1;
         end
      end else begin
         stb_take_s = 1'b0;
      end
      // The decision is taken in the last SEQ cycle so eth_start is a
      // registered output that is high during the COMMIT cycle itself.
      seq_last_s   = (state_q == ST_SEQ) && (byte_q == 2'd2);
      commit_ok_s  = seq_last_s && !bus.eth_busy && !eth_start_q;
      frame_drop_s = seq_last_s && !commit_ok_s;
   end

   // Main FSM with registered BRAM/transmitter outputs; outputs for a write
   // cycle are loaded on the edge that enters that cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_INIT;
         init_off_q   <= 4'd0;
         init_bank_q  <= 1'b0;
         byte_q       <= 2'd0;
         sample_cnt_q <= 5'd0;
         fill_bank_q  <= 1'b0;
         pending_q    <= 1'b0;
         cap_q        <= 32'h0000_0000;
         work_q       <= 32'h0000_0000;
         eth_start_q  <= 1'b0;
         eth_bank_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= 8'h00;
         wr_data_q    <= 8'h00;
         drop_q       <= 8'h00;
      end else begin
         wr_en_q     <= 1'b0;
         eth_start_q <= 1'b0;
         drop_q      <= sat_add(drop_q, stb_drop_s, frame_drop_s);

         if (stb_take_s) begin
            pending_q <= 1'b1;
            cap_q     <= {bus.pcm_r, bus.pcm_l};
         end else if (state_q == ST_IDLE) begin
            pending_q <= 1'b0;
         end else begin
            pending_q <= pending_q;
         end

         case (state_q)
            ST_INIT: begin
               if (init_bank_q && (init_off_q == 4'd14)) begin
                  state_q <= ST_IDLE;
               end else begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= {init_bank_q, 3'b000, init_off_q};
                  wr_data_q <= hdr_byte(init_off_q);
                  if (!init_bank_q && (init_off_q == 4'd13)) begin
                     init_bank_q <= 1'b1;
                     init_off_q  <= 4'd0;
                  end else begin
                     init_off_q  <= init_off_q + 4'd1;
                  end
               end
            end
            ST_IDLE: begin
               if (pending_q) begin
                  work_q    <= cap_q;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= {fill_bank_q, samp_base_s};
                  wr_data_q <= cap_q[7:0];
                  byte_q    <= 2'd1;
                  state_q   <= ST_SAMP;
               end else begin
                  state_q   <= ST_IDLE;
               end
            end
            ST_SAMP: begin
               if (byte_q != 2'd0) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= {fill_bank_q, samp_base_s + {5'b00000, byte_q}};
                  wr_data_q <= samp_byte(work_q, byte_q);
                  byte_q    <= byte_q + 2'd1;
               end else if (sample_cnt_q == LAST_IDX) begin
                  sample_cnt_q <= sample_cnt_q + 5'd1;
                  wr_en_q      <= 1'b1;
                  wr_addr_q    <= {fill_bank_q, 7'd14};
                  wr_data_q    <= seq_s[15:8];
                  byte_q       <= 2'd1;
                  state_q      <= ST_SEQ;
               end else begin
                  sample_cnt_q <= sample_cnt_q + 5'd1;
                  state_q      <= ST_IDLE;
               end
            end
            ST_SEQ: begin
               if (!seq_last_s) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= {fill_bank_q, 7'd15};
                  wr_data_q <= seq_s[7:0];
                  byte_q    <= 2'd2;
               end else begin
                  if (commit_ok_s) begin
                     eth_start_q <= 1'b1;
                     eth_bank_q  <= fill_bank_q;
                     fill_bank_q <= ~fill_bank_q;
                  end else begin
                     // Transmitter not ready: this bank is simply refilled.
                     fill_bank_q <= fill_bank_q;
                  end
                  state_q <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               sample_cnt_q <= 5'd0;
               state_q      <= ST_IDLE;
            end
            default: begin
               state_q     <= ST_INIT;
               init_off_q  <= 4'd0;
               init_bank_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef AU_PACKETIZER_SEQ_EN
   logic [15:0] seq_q;

   // Frame sequence counter: advances once per COMMIT, sent or dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         seq_q <= 16'h0000;
      end else if (state_q == ST_COMMIT) begin
         seq_q <= seq_q + 16'h0001;
      end else begin
         seq_q <= seq_q;
      end
   end

   assign seq_s = seq_q;
`else
   assign seq_s = 16'h0000;
`endif

   assign bus.eth_start    = eth_start_q;
   assign bus.eth_bank     = eth_bank_q;
   assign bus.bram_wr_en   = wr_en_q;
   assign bus.bram_wr_addr = wr_addr_q;
   assign bus.bram_wr_data = wr_data_q;
   assign bus.drop_cnt     = drop_q;

endmodule
